return_stack: RTL and testbench



---
 rtl/return_stack_pkg.sv | 13 +
 rtl/return_stack_ram.sv | 27 ++
 rtl/return_stack.sv | 139 +++++++++++++
 tb/tb_return_stack.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/return_stack_pkg.sv
// Shared encodings for the return-address stack: FSM states and the default geometry
// that the control unit and datapath both size against.
package return_stack_pkg;

    localparam int unsigned RS_DEPTH = 8;
    localparam int unsigned RS_WIDTH = 32;

    typedef enum logic {
        RS_RUN   = 1'b0,
        RS_FAULT = 1'b1
    } rs_state_e;

endpackage

// File: rtl/return_stack_ram.sv
// Return-stack storage: synchronous write, combinational read of the current top entry.
module return_stack_ram
    import return_stack_pkg::*;
#(
    parameter int unsigned WIDTH = RS_WIDTH,
    parameter int unsigned DEPTH = RS_DEPTH
) (
    input  logic                       clk,
    input  logic                       we,
    input  logic [$clog2(DEPTH)-1:0]   waddr,
    input  logic [WIDTH-1:0]           wdata,
    input  logic [$clog2(DEPTH)-1:0]   raddr,
    output logic [WIDTH-1:0]           rdata
);

    // Contents are deliberately not reset; entries above the pointer are never observable.
    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/return_stack.sv
// Return-address stack: pointer, full/empty decode and a sticky fault state that freezes
// the stack on overflow or underflow until clr_err.
module return_stack
    import return_stack_pkg::*;
#(
    parameter int unsigned WIDTH = RS_WIDTH,
    parameter int unsigned DEPTH = RS_DEPTH
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         StW,
    input  logic                         StR,
    input  logic [WIDTH-1:0]             push_data,
    input  logic                         clr_err,
    output logic [WIDTH-1:0]             pop_data,
    output logic                         pop_valid,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         empty,
    output logic                         full,
    output logic                         overflow,
    output logic                         underflow,
    output logic                         fault
);

    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned AW = $clog2(DEPTH);

    rs_state_e        state_q, state_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] pop_data_q, pop_data_d;
    logic             pop_valid_q, pop_valid_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;

    logic             is_empty, is_full;
    logic             ram_we;
    logic [AW-1:0]    ram_waddr, top_addr;
    logic [WIDTH-1:0] top_data;

    assign is_empty = (count_q == '0);
    assign is_full  = (count_q == CW'(DEPTH));
    // Wraps to the last slot when empty, but every read path is guarded by is_empty.
    assign top_addr = AW'(count_q - CW'(1));

    return_stack_ram #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH)
    ) u_ram (
        .clk  (clk),
        .we   (ram_we),
        .waddr(ram_waddr),
        .wdata(push_data),
        .raddr(top_addr),
        .rdata(top_data)
    );

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        pop_data_d  = pop_data_q;
        pop_valid_d = 1'b0;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        ram_we      = 1'b0;
        ram_waddr   = count_q[AW-1:0];

        unique case (state_q)
            RS_RUN: begin
                if (clr_err) begin
                    overflow_d  = 1'b0;
                    underflow_d = 1'b0;
                end
                if (StW && StR) begin
                    // Replace-top; on an empty stack the pushed value bypasses straight out.
                    pop_valid_d = 1'b1;
                    if (is_empty) begin
                        pop_data_d = push_data;
                    end else begin
                        pop_data_d = top_data;
                        ram_we     = 1'b1;
                        ram_waddr  = top_addr;
                    end
                end else if (StW) begin
                    if (is_full) begin
                        overflow_d = 1'b1;
                        state_d    = RS_FAULT;
                    end else begin
                        ram_we  = 1'b1;
                        count_d = count_q + CW'(1);
                    end
                end else if (StR) begin
                    if (is_empty) begin
                        underflow_d = 1'b1;
                        state_d     = RS_FAULT;
                    end else begin
                        pop_data_d  = top_data;
                        pop_valid_d = 1'b1;
                        count_d     = count_q - CW'(1);
                    end
                end
            end
            RS_FAULT: begin
                if (clr_err) begin
                    overflow_d  = 1'b0;
                    underflow_d = 1'b0;
                    state_d     = RS_RUN;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= RS_RUN;
            count_q     <= '0;
            pop_data_q  <= '0;
            pop_valid_q <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            pop_data_q  <= pop_data_d;
            pop_valid_q <= pop_valid_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign pop_data  = pop_data_q;
    assign pop_valid = pop_valid_q;
    assign count     = count_q;
    assign empty     = is_empty;
    assign full      = is_full;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;
    assign fault     = (state_q == RS_FAULT);

endmodule

// File: tb/tb_return_stack.sv
// Self-checking bench for return_stack (DEPTH=4, WIDTH=32): vector table plus a pop
// scoreboard, and a hand-written asynchronous-reset sequence.
module tb_return_stack;

    localparam int unsigned W = 32;
    localparam int unsigned D = 4;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         StW = 1'b0;
    logic         StR = 1'b0;
    logic [W-1:0] push_data = '0;
    logic         clr_err = 1'b0;
    logic [W-1:0] pop_data;
    logic         pop_valid;
    logic [2:0]   count;
    logic         empty, full, overflow, underflow, fault;

    return_stack #(
        .WIDTH(W),
        .DEPTH(D)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .StW      (StW),
        .StR      (StR),
        .push_data(push_data),
        .clr_err  (clr_err),
        .pop_data (pop_data),
        .pop_valid(pop_valid),
        .count    (count),
        .empty    (empty),
        .full     (full),
        .overflow (overflow),
        .underflow(underflow),
        .fault    (fault)
    );

    always #5 clk = ~clk;

    // flags = {empty, full, overflow, underflow, fault}
    typedef struct {
        logic         stw;
        logic         str;
        logic [W-1:0] din;
        logic         clr;
        logic         pv;
        logic [W-1:0] pd;
        logic [2:0]   cnt;
        logic [4:0]   flags;
    } vec_t;

    vec_t         vecs[$];
    logic [W-1:0] sb[$];
    int           tests = 0;
    int           fails = 0;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic stw, input logic str, input logic [W-1:0] din,
                       input logic clr, input logic pv, input logic [W-1:0] pd,
                       input logic [2:0] cnt, input logic [4:0] flags);
        vec_t v;
        v.stw = stw; v.str = str; v.din = din; v.clr = clr;
        v.pv = pv; v.pd = pd; v.cnt = cnt; v.flags = flags;
        vecs.push_back(v);
    endtask

    task automatic step(input logic stw, input logic str, input logic [W-1:0] din,
                        input logic clr);
        StW = stw; StR = str; push_data = din; clr_err = clr;
        @(posedge clk);
        #1;
        StW = 1'b0; StR = 1'b0; clr_err = 1'b0;
    endtask

    // Scoreboard: every pop_valid pulse must match the next expected popped address.
    always @(negedge clk) begin
        if (!reset && pop_valid) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL sb_unexpected_pop: got %h, expected no pop", pop_data);
            end else begin
                check("sb_pop_data", pop_data, sb.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        // Scenario 1: LIFO order, back-to-back pops
        add(1, 0, 32'h10, 0, 0, 32'h00, 3'd1, 5'b00000);
        add(1, 0, 32'h20, 0, 0, 32'h00, 3'd2, 5'b00000);
        add(1, 0, 32'h30, 0, 0, 32'h00, 3'd3, 5'b00000);
        add(0, 1, 32'h00, 0, 1, 32'h30, 3'd2, 5'b00000);
        add(0, 1, 32'h00, 0, 1, 32'h20, 3'd1, 5'b00000);
        add(0, 1, 32'h00, 0, 1, 32'h10, 3'd0, 5'b10000);
        add(0, 0, 32'h00, 0, 0, 32'h10, 3'd0, 5'b10000);
        // Scenario 2: overflow, frozen stack, clear with a simultaneous ignored strobe
        add(1, 0, 32'h41, 0, 0, 32'h10, 3'd1, 5'b00000);
        add(1, 0, 32'h42, 0, 0, 32'h10, 3'd2, 5'b00000);
        add(1, 0, 32'h43, 0, 0, 32'h10, 3'd3, 5'b00000);
        add(1, 0, 32'h44, 0, 0, 32'h10, 3'd4, 5'b01000);
        add(1, 0, 32'h50, 0, 0, 32'h10, 3'd4, 5'b01101);
        add(0, 1, 32'h00, 0, 0, 32'h10, 3'd4, 5'b01101);
        add(1, 0, 32'h99, 1, 0, 32'h10, 3'd4, 5'b01000);
        add(0, 1, 32'h00, 0, 1, 32'h44, 3'd3, 5'b00000);
        add(0, 1, 32'h00, 0, 1, 32'h43, 3'd2, 5'b00000);
        add(0, 1, 32'h00, 0, 1, 32'h42, 3'd1, 5'b00000);
        add(0, 1, 32'h00, 0, 1, 32'h41, 3'd0, 5'b10000);
        // Scenario 4: replace-top
        add(1, 0, 32'h0A, 0, 0, 32'h41, 3'd1, 5'b00000);
        add(1, 0, 32'h0B, 0, 0, 32'h41, 3'd2, 5'b00000);
        add(1, 1, 32'h0C, 0, 1, 32'h0B, 3'd2, 5'b00000);
        add(0, 1, 32'h00, 0, 1, 32'h0C, 3'd1, 5'b00000);
        add(0, 1, 32'h00, 0, 1, 32'h0A, 3'd0, 5'b10000);
        // Scenario 5: bypass on empty
        add(1, 1, 32'h77, 0, 1, 32'h77, 3'd0, 5'b10000);
        // Scenario 3: underflow, pop ignored in fault, clear
        add(0, 1, 32'h00, 0, 0, 32'h77, 3'd0, 5'b10011);
        add(0, 1, 32'h00, 0, 0, 32'h77, 3'd0, 5'b10011);
        add(0, 0, 32'h00, 1, 0, 32'h77, 3'd0, 5'b10000);

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        check("rst_count", 32'(count), 32'd0);
        check("rst_pop_data", pop_data, 32'h0);
        check("rst_flags", 32'({pop_valid, empty, full, overflow, underflow, fault}),
              32'b010000);
        reset = 1'b0;

        foreach (vecs[i]) begin
            StW = vecs[i].stw; StR = vecs[i].str;
            push_data = vecs[i].din; clr_err = vecs[i].clr;
            if (vecs[i].pv) sb.push_back(vecs[i].pd);
            @(posedge clk);
            #1;
            check($sformatf("v%0d_pop_valid", i), 32'(pop_valid), 32'(vecs[i].pv));
            check($sformatf("v%0d_pop_data", i), pop_data, vecs[i].pd);
            check($sformatf("v%0d_count", i), 32'(count), 32'(vecs[i].cnt));
            check($sformatf("v%0d_flags", i),
                  32'({empty, full, overflow, underflow, fault}), 32'(vecs[i].flags));
        end
        StW = 1'b0; StR = 1'b0; clr_err = 1'b0;
        @(posedge clk);
        #1;
        check("sb_drained", 32'(sb.size()), 32'd0);

        // Scenario 6: asynchronous reset during a pop cycle
        step(1, 0, 32'h1, 0);
        step(1, 0, 32'h2, 0);
        StR = 1'b1;
        @(posedge clk);
        #1;
        StR = 1'b0;
        check("s6_pop_valid_before", 32'(pop_valid), 32'd1);
        check("s6_pop_data_before", pop_data, 32'h2);
        #1;
        reset = 1'b1;
        #1;
        check("s6_rst_count", 32'(count), 32'd0);
        check("s6_rst_pop_data", pop_data, 32'h0);
        check("s6_rst_flags", 32'({pop_valid, empty, full, overflow, underflow, fault}),
              32'b010000);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        step(0, 1, 32'h0, 0);
        check("s6_underflow", 32'({pop_valid, count, underflow, fault}), 32'b0_000_1_1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
